// File: rtl/disp_sched.sv
// disp_sched -- sequencing controller for the shared two-channel display mux.
//
// Chooses whether timer A or timer B drives the single secs/mins display.
// When both timers run, the display alternates every DWELL_TICKS ticks of
// the 1 Hz strobe. The hold button freezes the display on a channel, and
// the toggle button swaps channels, both while showing and while frozen.
//
// Optional feature macro: HOLD_TIMEOUT_EN
//   When defined, a frozen display is released automatically after
//   HOLD_TICKS ticks, exactly as if the hold button had been pressed again.
//   When undefined, the display stays frozen until the hold button is
//   pressed, and HOLD_TICKS only takes part in the parameter range check.
//
// Parameters:
//   DWELL_TICKS  ticks one channel stays shown while both timers run (1..255)
//   HOLD_TICKS   ticks before automatic hold release (1..255)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   tick        one-cycle 1 Hz enable strobe
//   run_a       timer A running (level)
//   run_b       timer B running (level)
//   btn_hold    one-cycle debounced hold-button pulse
//   btn_toggle  one-cycle debounced toggle-button pulse
//   sela        mux select A (non-hold path)
//   selb        mux select B (non-hold path)
//   hold        mux hold-path enable
//   seldisp     mux hold-path channel, 1 = A
module disp_sched #(
    parameter int DWELL_TICKS = 5,
    parameter int HOLD_TICKS  = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic run_a,
    input  logic run_b,
    input  logic btn_hold,
    input  logic btn_toggle,
    output logic sela,
    output logic selb,
    output logic hold,
    output logic seldisp
);

    localparam int DW = $clog2(DWELL_TICKS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHOW_A = 2'd1;
    localparam logic [1:0] SHOW_B = 2'd2;
    localparam logic [1:0] FREEZE = 2'd3;

    if (DWELL_TICKS < 1 || DWELL_TICKS > 255 || HOLD_TICKS < 1 || HOLD_TICKS > 255) begin : g_bad_params
        $error("disp_sched: DWELL_TICKS and HOLD_TICKS must lie in 1..255");
    end

    logic [1:0]    state;
    logic [1:0]    nxt_state;
    logic [DW-1:0] dwell_cnt;
    logic [DW-1:0] nxt_dwell;
    logic          nxt_seldisp;
    logic          hold_timeout;

`ifdef HOLD_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    logic [HW-1:0] hold_cnt;

    // Outside FREEZE the counter sits at zero, so it always starts from zero
    // on FREEZE entry. Toggle presses deliberately do not restart it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state != FREEZE) begin
            hold_cnt <= '0;
        end else if (tick) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    assign hold_timeout = (state == FREEZE) && tick && (hold_cnt == HOLD_LAST);
`else
    assign hold_timeout = 1'b0;
`endif

    // Next-state logic. SHOW_A and SHOW_B share one branch: "own" is the
    // flag of the channel currently shown, "other" the flag of the one that
    // would be switched to.
    logic       own_run;
    logic       other_run;
    logic [1:0] other_state;
    logic [1:0] resolved;

    always_comb begin
        own_run     = (state == SHOW_A) ? run_a : run_b;
        other_run   = (state == SHOW_A) ? run_b : run_a;
        other_state = (state == SHOW_A) ? SHOW_B : SHOW_A;
        resolved    = run_a ? SHOW_A : (run_b ? SHOW_B : IDLE);

        nxt_state   = state;
        nxt_dwell   = dwell_cnt;
        nxt_seldisp = seldisp;

        case (state)
            IDLE: begin
                nxt_state = resolved;
            end
            SHOW_A, SHOW_B: begin
                if (!own_run) begin
                    nxt_state = other_run ? other_state : IDLE;
                end else if (btn_hold) begin
                    nxt_state   = FREEZE;
                    nxt_seldisp = (state == SHOW_A);
                end else if (btn_toggle && other_run) begin
                    nxt_state = other_state;
                end else if (!other_run) begin
                    nxt_dwell = '0;
                end else if (tick && dwell_cnt == DWELL_LAST) begin
                    nxt_state = other_state;
                end else if (tick) begin
                    nxt_dwell = dwell_cnt + DW'(1);
                end
            end
            default: begin
                // FREEZE: on release, prefer the channel that was on display
                // if its timer is still running, otherwise resolve normally.
                if (btn_hold || hold_timeout) begin
                    if (seldisp && run_a) begin
                        nxt_state = SHOW_A;
                    end else if (!seldisp && run_b) begin
                        nxt_state = SHOW_B;
                    end else begin
                        nxt_state = resolved;
                    end
                end else if (btn_toggle) begin
                    nxt_seldisp = ~seldisp;
                end
            end
        endcase

        if (nxt_state != state) begin
            nxt_dwell = '0;
        end
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so every output is a flop and follows an input event by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            sela      <= 1'b0;
            selb      <= 1'b0;
            hold      <= 1'b0;
            seldisp   <= 1'b1;
        end else begin
            state     <= nxt_state;
            dwell_cnt <= nxt_dwell;
            sela      <= (nxt_state == SHOW_A);
            selb      <= (nxt_state == SHOW_B);
            hold      <= (nxt_state == FREEZE);
            seldisp   <= nxt_seldisp;
        end
    end

endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched -- self-checking bench for disp_sched.
//
// A behavioural model tracks which channel is shown, whether the display is
// frozen, and how many ticks the current channel has been shown; a compare
// process checks the DUT against it on every falling edge. Directed steps
// add literal expectations worked out by hand.
// Works with or without HOLD_TIMEOUT_EN (HOLD_TICKS is set to 3 here).
module tb_disp_sched;

    localparam int DWELL = 5;
    localparam int HOLDT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic run_a = 1'b0;
    logic run_b = 1'b0;
    logic btn_hold = 1'b0;
    logic btn_toggle = 1'b0;
    logic sela;
    logic selb;
    logic hold;
    logic seldisp;

    int checks = 0;
    int errors = 0;

    disp_sched #(
        .DWELL_TICKS(DWELL),
        .HOLD_TICKS (HOLDT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .run_a     (run_a),
        .run_b     (run_b),
        .btn_hold  (btn_hold),
        .btn_toggle(btn_toggle),
        .sela      (sela),
        .selb      (selb),
        .hold      (hold),
        .seldisp   (seldisp)
    );

    always #5 clk = ~clk;

    // Model: shown channel (0 none, 1 A, 2 B), frozen flag, held channel,
    // ticks spent on the current channel while both run, ticks spent frozen.
    int mShown = 0;
    bit mFrozen = 1'b0;
    bit mDisp = 1'b1;
    int mTicks = 0;
    int mHoldTicks = 0;

    function automatic int pick(input bit a, input bit b);
        return a ? 1 : (b ? 2 : 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mShown = 0; mFrozen = 1'b0; mDisp = 1'b1; mTicks = 0; mHoldTicks = 0;
        end else if (mFrozen) begin
            bit release_now;
            release_now = btn_hold;
`ifdef HOLD_TIMEOUT_EN
            if (tick) begin
                mHoldTicks++;
                if (mHoldTicks >= HOLDT) release_now = 1'b1;
            end
`endif
            if (release_now) begin
                mFrozen = 1'b0;
                mTicks = 0;
                if (mDisp && run_a) mShown = 1;
                else if (!mDisp && run_b) mShown = 2;
                else mShown = pick(run_a, run_b);
            end else if (btn_toggle) begin
                mDisp = !mDisp;
            end
        end else if (mShown == 0) begin
            mShown = pick(run_a, run_b);
            mTicks = 0;
        end else begin
            bit mine, theirs;
            mine   = (mShown == 1) ? run_a : run_b;
            theirs = (mShown == 1) ? run_b : run_a;
            if (!mine) begin
                mShown = theirs ? 3 - mShown : 0;
                mTicks = 0;
            end else if (btn_hold) begin
                mFrozen = 1'b1;
                mDisp = (mShown == 1);
                mHoldTicks = 0;
                mTicks = 0;
            end else if (btn_toggle && theirs) begin
                mShown = 3 - mShown;
                mTicks = 0;
            end else if (!theirs) begin
                mTicks = 0;
            end else if (tick) begin
                mTicks++;
                if (mTicks == DWELL) begin
                    mShown = 3 - mShown;
                    mTicks = 0;
                end
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        bit eA, eB, eH;
        eA = !mFrozen && mShown == 1;
        eB = !mFrozen && mShown == 2;
        eH = mFrozen;
        checks++;
        if ({sela, selb, hold, seldisp} !== {eA, eB, eH, mDisp}) begin
            errors++;
            $display("[TB] FAIL model t=%0t: got sela/selb/hold/seldisp=%b%b%b%b expected %b%b%b%b",
                     $time, sela, selb, hold, seldisp, eA, eB, eH, mDisp);
        end
    end

    // Drive one cycle of inputs from a falling edge; pulses last one cycle.
    task automatic applyStimulus(input bit t, input bit h, input bit g, input bit ra, input bit rb);
        tick = t; btn_hold = h; btn_toggle = g; run_a = ra; run_b = rb;
        @(negedge clk);
        tick = 1'b0; btn_hold = 1'b0; btn_toggle = 1'b0;
    endtask

    task automatic checkOutput(input string name, input bit a, input bit b, input bit h, input bit d);
        checks++;
        if ({sela, selb, hold, seldisp} !== {a, b, h, d}) begin
            errors++;
            $display("[TB] FAIL %s: got sela/selb/hold/seldisp=%b%b%b%b expected %b%b%b%b",
                     name, sela, selb, hold, seldisp, a, b, h, d);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset", 0, 0, 0, 1);
        rst_n = 1'b1;

        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("enterA", 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 0, 1, 0);
            checkOutput("soloA", 1, 0, 0, 1);
        end

        // Both running: A for five ticks, then B for five, then A again.
        applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 1, 1);
            checkOutput("dwellA", 1, 0, 0, 1);
        end
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("dwellToB", 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 1, 1);
            checkOutput("dwellB", 0, 1, 0, 1);
        end
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("dwellToA", 1, 0, 0, 1);

        // Toggle on the same cycle as a tick: switch and restart the dwell.
        repeat (3) applyStimulus(1, 0, 0, 1, 1);
        applyStimulus(1, 0, 1, 1, 1);
        checkOutput("toggleTick", 0, 1, 0, 1);
        repeat (4) applyStimulus(1, 0, 0, 1, 1);
        checkOutput("dwellRestart", 0, 1, 0, 1);
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("dwellAfterToggle", 1, 0, 0, 1);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("toggleToB", 0, 1, 0, 1);

        // Freeze from B, toggle the held channel, release onto A.
        applyStimulus(0, 1, 0, 1, 1);
        checkOutput("holdFromB", 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("frozenToggle", 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 1, 1);
        checkOutput("releaseToA", 1, 0, 0, 1);

        // Hold and toggle together: hold wins, no toggle.
        applyStimulus(0, 1, 1, 1, 1);
        checkOutput("holdBeatsToggle", 0, 0, 1, 1);

        // Run flags ignored while frozen; release falls back to B.
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("frozenIgnoresRun", 0, 0, 1, 1);
        repeat (2) applyStimulus(1, 0, 0, 0, 1);
        checkOutput("frozenTwoTicks", 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 1);
`ifdef HOLD_TIMEOUT_EN
        checkOutput("holdTimeout", 0, 1, 0, 1);
`else
        checkOutput("noTimeout", 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("releaseFallback", 0, 1, 0, 1);
`endif

        // Shown timer stops: move to the other, then to IDLE.
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("stopBtoA", 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("stopToIdle", 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("idleIgnoresButtons", 0, 0, 0, 1);

        // Asynchronous reset in the middle of FREEZE.
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("enterB", 0, 1, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("holdB", 0, 0, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        checkOutput("inReset", 0, 0, 0, 1);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("afterReset", 0, 1, 0, 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
